// File: rtl/eth_rx_frame_fifo.sv
// Purpose: store-and-forward receive frame buffer; frames flagged bad or overflowing are dropped whole.
// Latency: good frame tlast accepted at edge N -> first output byte valid after edge N+1.
// Backpressure: none upstream (a full buffer drops the frame); m_axis holds data stable while tready=0.
module eth_rx_frame_fifo #(
  parameter int DEPTH      = 4096,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       status_overflow,
  output logic       status_bad_frame,
  output logic       status_good_frame
);

  // One buffer entry: the byte plus its end-of-frame marker.
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } entry_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_P = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);

  entry_t mem [DEPTH];

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [ADDR_WIDTH:0] wr_ptr_cur;     // next write location (includes uncommitted bytes)
  logic [ADDR_WIDTH:0] wr_ptr_commit;  // one past the last byte of the last good frame
  logic [ADDR_WIDTH:0] rd_ptr;         // next byte to move into the output register
  logic                drop_reg;       // rest of the current frame is being discarded

  logic [ADDR_WIDTH:0] used;
  logic                full;
  logic                empty;
  logic                wr_en;
  logic                rd_en;

  // Occupancy flags, RAM write enable and output-stage load decision.
  always_comb begin
    used  = wr_ptr_cur - rd_ptr;
    full  = (used == DEPTH_P);
    // Only committed bytes are readable, so a partial frame never leaks out.
    empty = (rd_ptr == wr_ptr_commit);
    // A bad frame's tlast byte is never stored; the frame is rewound instead.
    wr_en = s_axis_tvalid && !drop_reg && !full && !(s_axis_tlast && s_axis_tuser);
    rd_en = !empty && (!m_axis_tvalid || m_axis_tready);
  end

  // Frame storage; no reset needed because only committed entries are ever read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_cur[ADDR_WIDTH-1:0]] <= '{last: s_axis_tlast, data: s_axis_tdata};
    end
  end

  // Write-side frame accounting: advance, commit on good tlast, rewind on drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_cur        <= '0;
      wr_ptr_commit     <= '0;
      drop_reg          <= 1'b0;
      status_overflow   <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_good_frame <= 1'b0;
    end else begin
      status_overflow   <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_good_frame <= 1'b0;
      if (s_axis_tvalid) begin
        if (s_axis_tlast) begin
          // Overflow outranks a bad-FCS flag: only one drop reason is reported.
          if (drop_reg || full) begin
            wr_ptr_cur      <= wr_ptr_commit;
            drop_reg        <= 1'b0;
            status_overflow <= 1'b1;
          end else if (s_axis_tuser) begin
            wr_ptr_cur       <= wr_ptr_commit;
            status_bad_frame <= 1'b1;
          end else begin
            wr_ptr_cur        <= wr_ptr_cur + PTR_ONE;
            wr_ptr_commit     <= wr_ptr_cur + PTR_ONE;
            status_good_frame <= 1'b1;
          end
        end else if (!drop_reg) begin
          // First byte that finds the buffer full poisons the remainder of the frame.
          if (full) begin
            drop_reg <= 1'b1;
          end else begin
            wr_ptr_cur <= wr_ptr_cur + PTR_ONE;
          end
        end
      end
    end
  end

  // Registered output stage: refill whenever empty or the current byte is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (rd_en) begin
      m_axis_tdata  <= mem[rd_ptr[ADDR_WIDTH-1:0]].data;
      m_axis_tlast  <= mem[rd_ptr[ADDR_WIDTH-1:0]].last;
      m_axis_tvalid <= 1'b1;
      rd_ptr        <= rd_ptr + PTR_ONE;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  logic [ADDR_WIDTH:0] committed;

  // Committed span measured from the read pointer, for the sanity properties below.
  always_comb begin
    committed = wr_ptr_commit - rd_ptr;
  end

  // The buffer never holds more than DEPTH bytes.
  assert property (@(posedge clk) disable iff (rst) used <= DEPTH_P);
  // The commit pointer never runs ahead of the write pointer.
  assert property (@(posedge clk) disable iff (rst) committed <= used);
`endif

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Purpose: self-checking bench for eth_rx_frame_fifo using a frame-level reference model.
// Latency: checks first output byte one cycle after a good frame's tlast edge.
// Backpressure: drives tready patterns (held low, toggling, always high) and checks data hold.
module tb_eth_rx_frame_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tlast;
  logic       s_tuser;
  logic       m_tready;

  logic [7:0] b_tdata;
  logic       b_tvalid, b_tlast, b_ovf, b_bad, b_good;
  logic [7:0] t_tdata;
  logic       t_tvalid, t_tlast, t_ovf, t_bad, t_good;

  eth_rx_frame_fifo #(.DEPTH(4096)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(b_tlast),
    .status_overflow(b_ovf), .status_bad_frame(b_bad), .status_good_frame(b_good)
  );

  eth_rx_frame_fifo #(.DEPTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(t_tdata), .m_axis_tvalid(t_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(t_tlast),
    .status_overflow(t_ovf), .status_bad_frame(t_bad), .status_good_frame(t_good)
  );

  // Observed instance: 0 = 4096-byte buffer, 1 = 16-byte buffer.
  logic       sel16;
  logic [7:0] o_tdata;
  logic       o_tvalid, o_tlast, o_ovf, o_bad, o_good;

  always_comb begin
    o_tdata  = sel16 ? t_tdata  : b_tdata;
    o_tvalid = sel16 ? t_tvalid : b_tvalid;
    o_tlast  = sel16 ? t_tlast  : b_tlast;
    o_ovf    = sel16 ? t_ovf    : b_ovf;
    o_bad    = sel16 ? t_bad    : b_bad;
    o_good   = sel16 ? t_good   : b_good;
  end

  // Output monitor: collects transferred bytes, counts status pulses, detects unstable held data.
  logic [8:0] rx_q[$];
  int         good_cnt = 0;
  int         bad_cnt  = 0;
  int         ovf_cnt  = 0;
  int         hold_err = 0;
  logic       stall_prev = 1'b0;
  logic [8:0] stall_val  = '0;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev && (!o_tvalid || {o_tlast, o_tdata} != stall_val)) hold_err <= hold_err + 1;
      stall_prev <= o_tvalid && !m_tready;
      stall_val  <= {o_tlast, o_tdata};
      if (o_tvalid && m_tready) rx_q.push_back({o_tlast, o_tdata});
      if (o_good) good_cnt <= good_cnt + 1;
      if (o_bad)  bad_cnt  <= bad_cnt + 1;
      if (o_ovf)  ovf_cnt  <= ovf_cnt + 1;
    end
  end

  // Reference model output: the bytes of every frame the model says must be forwarded.
  logic [8:0] exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1);
  end

  task automatic stop_tx();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic idle(int n);
    stop_tx();
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(logic [7:0] d, logic last, logic user);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    s_tuser  = user;
    @(posedge clk);
    #1;
  endtask

  // Sends one frame; keep=1 means the model expects it on the output.
  task automatic send_frame(int len, logic user, logic keep);
    for (int i = 0; i < len; i++) begin
      logic [7:0] d;
      logic       last;
      d    = 8'($urandom_range(0, 255));
      last = (i == len - 1);
      if (keep) exp_q.push_back({last, d});
      send_byte(d, last, last & user);
    end
  endtask

  task automatic wait_rx(int target, int budget);
    for (int c = 0; c < budget && rx_q.size() < target; c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stop_tx();
    s_tdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic int count_mismatch(int base);
    int m = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i >= rx_q.size()) m++;
      else if (rx_q[base + i] !== exp_q[i]) m++;
    end
    return m;
  endfunction

  task automatic test_reset();
    sel16 = 1'b0; m_tready = 1'b1; s_tdata = 8'h00;
    rst = 1'b1;
    stop_tx();
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (b_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b expected 0", b_tvalid); else n_pass++;
    n_chk++; if (b_tdata !== 8'h00) $display("FAIL reset_tdata: got %h expected 00", b_tdata); else n_pass++;
    n_chk++; if (b_tlast !== 1'b0) $display("FAIL reset_tlast: got %b expected 0", b_tlast); else n_pass++;
    n_chk++; if ({b_ovf, b_bad, b_good} !== 3'b000) $display("FAIL reset_status: got %b expected 000", {b_ovf, b_bad, b_good}); else n_pass++;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if ({t_tvalid, t_tlast, t_tdata} !== 10'h000) $display("FAIL reset_idle16: got %h expected 000", {t_tvalid, t_tlast, t_tdata}); else n_pass++;
    n_chk++; if (b_tvalid !== 1'b0) $display("FAIL reset_idle_tvalid: got %b expected 0", b_tvalid); else n_pass++;
  endtask

  task automatic test_good_frame();
    int base, g0, b0, o0;
    do_reset();
    sel16 = 1'b0; m_tready = 1'b1;
    exp_q.delete();
    base = rx_q.size(); g0 = good_cnt; b0 = bad_cnt; o0 = ovf_cnt;
    send_frame(64, 1'b0, 1'b1);
    n_chk++; if (o_tvalid !== 1'b0) $display("FAIL latency_early: got tvalid %b expected 0", o_tvalid); else n_pass++;
    stop_tx();
    @(posedge clk);
    #1;
    n_chk++; if (o_tvalid !== 1'b1) $display("FAIL latency_first: got tvalid %b expected 1", o_tvalid); else n_pass++;
    n_chk++; if ({o_tlast, o_tdata} !== exp_q[0]) $display("FAIL first_byte: got %h expected %h", {o_tlast, o_tdata}, exp_q[0]); else n_pass++;
    wait_rx(base + 64, 300);
    idle(5);
    n_chk++; if (rx_q.size() - base !== 64) $display("FAIL good64_count: got %0d expected 64", rx_q.size() - base); else n_pass++;
    n_chk++; if (count_mismatch(base) !== 0) $display("FAIL good64_data: got %0d bad bytes expected 0", count_mismatch(base)); else n_pass++;
    n_chk++; if (good_cnt - g0 !== 1) $display("FAIL good64_pulse: got %0d expected 1", good_cnt - g0); else n_pass++;
    n_chk++; if ((bad_cnt - b0) + (ovf_cnt - o0) !== 0) $display("FAIL good64_drops: got %0d expected 0", (bad_cnt - b0) + (ovf_cnt - o0)); else n_pass++;
  endtask

  task automatic test_bad_frame();
    int base, g0, b0, o0;
    do_reset();
    sel16 = 1'b0; m_tready = 1'b1;
    exp_q.delete();
    base = rx_q.size(); g0 = good_cnt; b0 = bad_cnt; o0 = ovf_cnt;
    send_frame(100, 1'b1, 1'b0);
    send_frame(60, 1'b0, 1'b1);
    stop_tx();
    wait_rx(base + 60, 400);
    idle(10);
    n_chk++; if (rx_q.size() - base !== 60) $display("FAIL bad_count: got %0d expected 60", rx_q.size() - base); else n_pass++;
    n_chk++; if (count_mismatch(base) !== 0) $display("FAIL bad_data: got %0d bad bytes expected 0", count_mismatch(base)); else n_pass++;
    n_chk++; if (bad_cnt - b0 !== 1) $display("FAIL bad_pulse: got %0d expected 1", bad_cnt - b0); else n_pass++;
    n_chk++; if (good_cnt - g0 !== 1) $display("FAIL bad_good_pulse: got %0d expected 1", good_cnt - g0); else n_pass++;
    n_chk++; if (ovf_cnt - o0 !== 0) $display("FAIL bad_ovf_pulse: got %0d expected 0", ovf_cnt - o0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int base, g0, h0, nlast;
    do_reset();
    sel16 = 1'b0; m_tready = 1'b1;
    exp_q.delete();
    base = rx_q.size(); g0 = good_cnt; h0 = hold_err;
    fork
      begin
        for (int f = 0; f < 3; f++) send_frame(64, 1'b0, 1'b1);
        stop_tx();
      end
      begin
        for (int c = 0; c < 2000 && rx_q.size() < base + 192; c++) begin
          m_tready = (c % 2 == 0);
          @(posedge clk);
          #1;
        end
      end
    join
    m_tready = 1'b1;
    idle(5);
    nlast = 0;
    for (int i = base; i < rx_q.size(); i++) if (rx_q[i][8]) nlast++;
    n_chk++; if (rx_q.size() - base !== 192) $display("FAIL b2b_count: got %0d expected 192", rx_q.size() - base); else n_pass++;
    n_chk++; if (count_mismatch(base) !== 0) $display("FAIL b2b_data: got %0d bad bytes expected 0", count_mismatch(base)); else n_pass++;
    n_chk++; if (nlast !== 3) $display("FAIL b2b_tlast: got %0d expected 3", nlast); else n_pass++;
    n_chk++; if (hold_err - h0 !== 0) $display("FAIL b2b_hold: got %0d unstable cycles expected 0", hold_err - h0); else n_pass++;
    n_chk++; if (good_cnt - g0 !== 3) $display("FAIL b2b_pulses: got %0d expected 3", good_cnt - g0); else n_pass++;
  endtask

  task automatic test_overflow();
    int base, g0, o0;
    do_reset();
    sel16 = 1'b1; m_tready = 1'b0;
    exp_q.delete();
    base = rx_q.size(); g0 = good_cnt; o0 = ovf_cnt;
    send_frame(10, 1'b0, 1'b1);
    idle(3);
    send_frame(10, 1'b0, 1'b0);
    idle(3);
    n_chk++; if (ovf_cnt - o0 !== 1) $display("FAIL ovf_pulse: got %0d expected 1", ovf_cnt - o0); else n_pass++;
    n_chk++; if (good_cnt - g0 !== 1) $display("FAIL ovf_good_pulse: got %0d expected 1", good_cnt - g0); else n_pass++;
    m_tready = 1'b1;
    wait_rx(base + 10, 100);
    idle(5);
    n_chk++; if (rx_q.size() - base !== 10) $display("FAIL ovf_count: got %0d expected 10", rx_q.size() - base); else n_pass++;
    send_frame(6, 1'b0, 1'b1);
    stop_tx();
    wait_rx(base + 16, 100);
    idle(5);
    n_chk++; if (rx_q.size() - base !== 16) $display("FAIL ovf_after_count: got %0d expected 16", rx_q.size() - base); else n_pass++;
    n_chk++; if (count_mismatch(base) !== 0) $display("FAIL ovf_data: got %0d bad bytes expected 0", count_mismatch(base)); else n_pass++;
    n_chk++; if (good_cnt - g0 !== 2) $display("FAIL ovf_after_pulse: got %0d expected 2", good_cnt - g0); else n_pass++;
  endtask

  // Random frame lengths around the 16-byte capacity with tready low while filling.
  // With tready held low, one committed byte sits in the output register, so the RAM
  // holds (committed - 1) bytes and a frame of L fits iff that plus L is at most 16.
  task automatic test_random_overflow();
    int base, g0, b0, o0, eg, eb, eo;
    do_reset();
    sel16 = 1'b1;
    exp_q.delete();
    base = rx_q.size(); g0 = good_cnt; b0 = bad_cnt; o0 = ovf_cnt;
    eg = 0; eb = 0; eo = 0;
    for (int r = 0; r < 8; r++) begin
      int occ;
      occ = 0;
      m_tready = 1'b0;
      for (int f = 0; f < 5; f++) begin
        int   len, in_ram;
        logic user;
        len    = $urandom_range(1, 20);
        user   = ($urandom_range(0, 3) == 0);
        in_ram = (occ > 0) ? occ - 1 : 0;
        if (in_ram + len > 16) begin
          eo++;
          send_frame(len, user, 1'b0);
        end else if (user) begin
          eb++;
          send_frame(len, user, 1'b0);
        end else begin
          eg++;
          occ += len;
          send_frame(len, user, 1'b1);
        end
        idle(3);
      end
      m_tready = 1'b1;
      wait_rx(base + exp_q.size(), 200);
      idle(3);
    end
    n_chk++; if (rx_q.size() - base !== exp_q.size()) $display("FAIL rnd_count: got %0d expected %0d", rx_q.size() - base, exp_q.size()); else n_pass++;
    n_chk++; if (count_mismatch(base) !== 0) $display("FAIL rnd_data: got %0d bad bytes expected 0", count_mismatch(base)); else n_pass++;
    n_chk++; if (good_cnt - g0 !== eg) $display("FAIL rnd_good: got %0d expected %0d", good_cnt - g0, eg); else n_pass++;
    n_chk++; if (bad_cnt - b0 !== eb) $display("FAIL rnd_bad: got %0d expected %0d", bad_cnt - b0, eb); else n_pass++;
    n_chk++; if (ovf_cnt - o0 !== eo) $display("FAIL rnd_ovf: got %0d expected %0d", ovf_cnt - o0, eo); else n_pass++;
  endtask

  task automatic test_wrap();
    int base, g0, o0;
    do_reset();
    sel16 = 1'b1; m_tready = 1'b1;
    exp_q.delete();
    base = rx_q.size(); g0 = good_cnt; o0 = ovf_cnt;
    for (int f = 0; f < 200; f++) send_frame(7, 1'b0, 1'b1);
    stop_tx();
    wait_rx(base + 1400, 3000);
    idle(5);
    n_chk++; if (rx_q.size() - base !== 1400) $display("FAIL wrap_count: got %0d expected 1400", rx_q.size() - base); else n_pass++;
    n_chk++; if (count_mismatch(base) !== 0) $display("FAIL wrap_data: got %0d bad bytes expected 0", count_mismatch(base)); else n_pass++;
    n_chk++; if (ovf_cnt - o0 !== 0) $display("FAIL wrap_ovf: got %0d expected 0", ovf_cnt - o0); else n_pass++;
    n_chk++; if (good_cnt - g0 !== 200) $display("FAIL wrap_good: got %0d expected 200", good_cnt - g0); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int base;
    do_reset();
    sel16 = 1'b0; m_tready = 1'b0;
    exp_q.delete();
    send_frame(64, 1'b0, 1'b0);
    idle(2);
    m_tready = 1'b1;
    send_frame(20, 1'b0, 1'b0);
    n_chk++; if (o_tvalid !== 1'b1) $display("FAIL midrst_streaming: got tvalid %b expected 1", o_tvalid); else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++; if (o_tvalid !== 1'b0) $display("FAIL midrst_tvalid: got %b expected 0", o_tvalid); else n_pass++;
    n_chk++; if ({o_tlast, o_tdata} !== 9'h000) $display("FAIL midrst_data: got %h expected 000", {o_tlast, o_tdata}); else n_pass++;
    stop_tx();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    base = rx_q.size();
    send_frame(64, 1'b0, 1'b1);
    stop_tx();
    wait_rx(base + 64, 300);
    idle(10);
    n_chk++; if (rx_q.size() - base !== 64) $display("FAIL midrst_count: got %0d expected 64", rx_q.size() - base); else n_pass++;
    n_chk++; if (count_mismatch(base) !== 0) $display("FAIL midrst_data_out: got %0d bad bytes expected 0", count_mismatch(base)); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; sel16 = 1'b0; m_tready = 1'b1; s_tdata = 8'h00;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    test_reset();
    test_good_frame();
    test_bad_frame();
    test_back_to_back();
    test_overflow();
    test_random_overflow();
    test_wrap();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
